// File: rtl/bicubic_fetch_if.sv
// Configuration, image-ROM port and window handshake bundle for bicubic_fetch.
// master: the fetch unit. slave: the job issuer / ROM / interpolation core side.
interface bicubic_fetch_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic [6:0]        h0;
  logic [6:0]        v0;
  logic [4:0]        sw;
  logic [4:0]        sh;
  logic [5:0]        dw;
  logic [5:0]        dh;
  logic [ADDR_W-1:0] img_addr;
  logic              img_rd;
  logic [7:0]        img_data;
  logic              win_valid;
  logic              win_ready;
  logic [127:0]      win_pix;
  logic [31:0]       win_xh;
  logic [31:0]       win_xv;
  logic              busy;
  logic              done;

  modport master (
    input  start, h0, v0, sw, sh, dw, dh, img_data, win_ready,
    output img_addr, img_rd, win_valid, win_pix, win_xh, win_xv, busy, done
  );

  modport slave (
    output start, h0, v0, sw, sh, dw, dh, img_data, win_ready,
    input  img_addr, img_rd, win_valid, win_pix, win_xh, win_xv, busy, done
  );
endinterface

// File: rtl/bicubic_fetch.sv
// Bicubic window fetcher: walks the destination grid in raster order, maps each
// pixel to a source coordinate (integer + Q0.8 fraction), reads the 4x4 source
// neighbourhood from the image ROM and builds the {1, t, t^2, t^3} power vectors.
// Optional feature: define BICUBIC_FETCH_CLAMP_EN to clamp neighbourhood indices
// to the source image bounds before address generation.
module bicubic_fetch #(
  parameter int SRC_W  = 100,
  parameter int SRC_H  = 100,
  parameter int ADDR_W = 14
) (
  input logic             clk,
  input logic             rst,
  bicubic_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, STEP, DIV_Y, DIV_X, POW, FETCH, PRESENT} state_t;

`ifdef BICUBIC_FETCH_CLAMP_EN
  localparam logic [8:0] ROW_MAX = 9'(SRC_H - 1);
  localparam logic [8:0] COL_MAX = 9'(SRC_W - 1);
`endif

  state_t       state, state_nx;
  logic [4:0]   cnt;
  logic [6:0]   cfg_h0;
  logic [4:0]   cfg_sw, cfg_sh;
  logic [5:0]   cfg_dw, cfg_dh;
  logic [7:0]   col_idx, row_idx;
  logic [5:0]   col_rem, row_rem;
  logic [5:0]   col_cnt, row_cnt;
  logic [13:0]  div_p;
  logic [12:0]  div_dv;
  logic [7:0]   div_q;
  logic [7:0]   frac_x, frac_y, x2, y2;
  logic [127:0] win_pix;
  logic [31:0]  win_xh, win_xv;
  logic         done;

  // Derived step quantities (divisor D = size-1, step = window-1).
  logic [4:0]   sw_m1, sh_m1;
  logic [5:0]   dw_m1, dh_m1;
  logic         last_win;
  logic [6:0]   col_sum, row_sum, col_sub, row_sub;
  logic         col_wrap, row_wrap;

  assign sw_m1    = cfg_sw - 5'd1;
  assign sh_m1    = cfg_sh - 5'd1;
  assign dw_m1    = cfg_dw - 6'd1;
  assign dh_m1    = cfg_dh - 6'd1;
  assign last_win = (col_cnt == dw_m1) && (row_cnt == dh_m1);
  assign col_sum  = {1'b0, col_rem} + {2'b00, sw_m1};
  assign row_sum  = {1'b0, row_rem} + {2'b00, sh_m1};
  assign col_sub  = col_sum - {1'b0, dw_m1};
  assign row_sub  = row_sum - {1'b0, dh_m1};
  assign col_wrap = col_sum >= {1'b0, dw_m1};
  assign row_wrap = row_sum >= {1'b0, dh_m1};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = STEP;
      STEP:    state_nx = (col_cnt == 6'd0) ? DIV_Y : DIV_X;
      DIV_Y:   if (cnt == 5'd7) state_nx = DIV_X;
      DIV_X:   if (cnt == 5'd7) state_nx = POW;
      POW:     if (cnt == 5'd1) state_nx = FETCH;
      FETCH:   if (cnt == 5'd16) state_nx = PRESENT;
      PRESENT: if (bus.win_ready) state_nx = last_win ? IDLE : STEP;
      default: state_nx = IDLE;
    endcase
  end

  // Restoring divider step: shifted divisor D<<7 walks down one bit per cycle.
  logic [5:0]  div_d, div_rem;
  logic [13:0] div_pin, div_pnx;
  logic [12:0] div_dvin;
  logic        div_ge;
  always_comb begin
    div_d   = (state == DIV_Y) ? dh_m1 : dw_m1;
    div_rem = (state == DIV_Y) ? row_rem : col_rem;
    if (cnt == 5'd0) begin
      div_pin  = {div_rem, 8'd0} + {9'd0, div_d[5:1]};
      div_dvin = {div_d, 7'd0};
    end else begin
      div_pin  = div_p;
      div_dvin = div_dv;
    end
    // D = 0 leaves every quotient bit clear, so the fraction comes out zero.
    div_ge  = (div_d != 6'd0) && (div_pin >= {1'b0, div_dvin});
    div_pnx = div_ge ? (div_pin - {1'b0, div_dvin}) : div_pin;
  end

  // Power products, rounded back to Q0.8.
  logic [15:0] x_sq, y_sq, x_cu, y_cu;
  always_comb begin
    x_sq = {8'd0, frac_x} * {8'd0, frac_x} + 16'd128;
    y_sq = {8'd0, frac_y} * {8'd0, frac_y} + 16'd128;
    x_cu = {8'd0, x2} * {8'd0, frac_x} + 16'd128;
    y_cu = {8'd0, y2} * {8'd0, frac_y} + 16'd128;
  end

  // ROM address of neighbourhood element cnt; indices carry a +1 offset so -1 is representable.
  logic [8:0] row_p1, col_p1, row_a, col_a;
  always_comb begin
    row_p1 = {1'b0, row_idx} + {7'd0, cnt[3:2]};
    col_p1 = {1'b0, col_idx} + {7'd0, cnt[1:0]};
`ifdef BICUBIC_FETCH_CLAMP_EN
    row_a = (row_p1 == 9'd0) ? 9'd0 : row_p1 - 9'd1;
    col_a = (col_p1 == 9'd0) ? 9'd0 : col_p1 - 9'd1;
    if (row_a > ROW_MAX) row_a = ROW_MAX;
    if (col_a > COL_MAX) col_a = COL_MAX;
`else
    row_a = row_p1 - 9'd1;
    col_a = col_p1 - 9'd1;
`endif
    bus.img_rd   = (state == FETCH) && !cnt[4];
    bus.img_addr = bus.img_rd ? ADDR_W'(int'(row_a) * SRC_W + int'(col_a)) : '0;
  end

  assign bus.busy      = (state != IDLE);
  assign bus.win_valid = (state == PRESENT);
  assign bus.win_pix   = win_pix;
  assign bus.win_xh    = win_xh;
  assign bus.win_xv    = win_xv;
  assign bus.done      = done;

  // Datapath: grid walk, divider, powers, window capture and handshake bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      cnt <= '0;  cfg_h0 <= '0; cfg_sw <= '0; cfg_sh <= '0; cfg_dw <= '0; cfg_dh <= '0;
      col_idx <= '0; row_idx <= '0; col_rem <= '0; row_rem <= '0;
      col_cnt <= '0; row_cnt <= '0;
      div_p <= '0; div_dv <= '0; div_q <= '0;
      frac_x <= '0; frac_y <= '0; x2 <= '0; y2 <= '0;
      win_pix <= '0; win_xh <= '0; win_xv <= '0; done <= 1'b0;
    end else begin
      cnt  <= (state_nx != state) ? 5'd0 : cnt + 5'd1;
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          cfg_h0  <= bus.h0;  cfg_sw <= bus.sw; cfg_sh <= bus.sh;
          cfg_dw  <= bus.dw;  cfg_dh <= bus.dh;
          col_idx <= {1'b0, bus.h0}; row_idx <= {1'b0, bus.v0};
          col_rem <= '0; row_rem <= '0; col_cnt <= '0; row_cnt <= '0;
        end
        STEP: if (col_cnt == 6'd0) begin
          col_idx <= {1'b0, cfg_h0};
          col_rem <= '0;
          if (row_cnt != 6'd0) begin
            row_rem <= row_wrap ? row_sub[5:0] : row_sum[5:0];
            if (row_wrap) row_idx <= row_idx + 8'd1;
          end
        end else begin
          // sw <= dw keeps the remainder below 2*D, so one subtraction suffices.
          col_rem <= col_wrap ? col_sub[5:0] : col_sum[5:0];
          if (col_wrap) col_idx <= col_idx + 8'd1;
        end
        DIV_Y, DIV_X: begin
          div_p  <= div_pnx;
          div_dv <= div_dvin >> 1;
          div_q  <= {div_q[6:0], div_ge};
          if (cnt == 5'd7) begin
            if (state == DIV_Y) frac_y <= {div_q[6:0], div_ge};
            else                frac_x <= {div_q[6:0], div_ge};
          end
        end
        POW: if (cnt == 5'd0) begin
          x2 <= x_sq[15:8];
          y2 <= y_sq[15:8];
        end else begin
          win_xh <= {8'hFF, frac_x, x2, x_cu[15:8]};
          win_xv <= {8'hFF, frac_y, y2, y_cu[15:8]};
        end
        FETCH: if (cnt != 5'd0) begin
          win_pix[{cnt[3:0] - 4'd1, 3'b000} +: 8] <= bus.img_data;
        end
        PRESENT: if (bus.win_ready) begin
          if (col_cnt == dw_m1) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 6'd1;
          end else begin
            col_cnt <= col_cnt + 6'd1;
          end
          if (last_win) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
